// File: rtl/vram_gen.sv
// vram_gen: parametrised dual-port video RAM with RAS/CAS random port
// and a serial access memory (SAM) port supporting read/write transfers.
module vram_gen #(
  parameter int DATA_W = 8,
  parameter int ROW_W  = 8,
  parameter int COL_W  = 8,
  parameter int AD_W   = 8,
  parameter bit WPB_EN = 1'b1
) (
  input  logic              MCLK,
  input  logic              reset,
  input  logic              RAS,
  input  logic              CAS,
  input  logic              WE,
  input  logic              OE,
  input  logic              SC,
  input  logic              SE,
  input  logic [AD_W-1:0]   AD,
  input  logic [DATA_W-1:0] RD_i,
  output logic [DATA_W-1:0] RD_o,
  output logic              RD_d,
  input  logic [DATA_W-1:0] SD_i,
  output logic [DATA_W-1:0] SD_o,
  output logic              SD_d
);

  localparam int SAM_N = 1 << COL_W;
  localparam int DEPTH = 1 << (ROW_W + COL_W);

  typedef enum logic [2:0] {
    CY_NONE,
    CY_NORM,
    CY_WPB,
    CY_RX,
    CY_WX,
    CY_CBR
  } cyc_e;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] sam [SAM_N];

  logic              ras_q;
  logic              cas_q;
  logic              oe_q;
  logic              sc_q;
  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  col_q;
  logic [COL_W-1:0]  ptr_q;
  logic              mode_in;
  cyc_e              cyc_q;
  cyc_e              cyc_d;
  logic [DATA_W-1:0] mask_q;
  logic [DATA_W-1:0] mask_d;

  logic                    cas_act;
  logic                    ras_fall;
  logic                    ras_rise;
  logic                    cas_rise;
  logic                    oe_rise;
  logic                    sc_rise;
  logic                    col_lat;
  logic                    do_wr;
  logic                    rx;
  logic                    wx;
  logic [COL_W-1:0]        col_eff;
  logic [ROW_W+COL_W-1:0]  waddr;

  assign cas_act  = ~RAS & ~CAS;
  assign ras_fall = ras_q & ~RAS;
  assign ras_rise = ~ras_q & RAS;
  assign cas_rise = cas_act & ~cas_q;
  assign oe_rise  = ~oe_q & OE;
  assign sc_rise  = ~sc_q & SC;

  // CBR never latches a column: its CAS rise lands while cyc_q is NONE
  assign col_lat = cas_rise &
    (cyc_q inside {CY_NORM, CY_WPB, CY_RX, CY_WX});
  assign col_eff = col_lat ? AD[COL_W-1:0] : col_q;
  assign waddr   = {row_q, col_eff};

  assign do_wr = ~reset & cas_act & ~WE &
    (cyc_q inside {CY_NORM, CY_WPB});
  assign rx = oe_rise & (cyc_q == CY_RX);
  assign wx = cas_rise & (cyc_q == CY_WX);

  assign RD_d = ~(cas_act & ~OE &
    (cyc_q inside {CY_NORM, CY_WPB}));
  assign SD_d = SE | mode_in;

  always_comb begin
    cyc_d  = cyc_q;
    mask_d = mask_q;
    if (ras_rise) begin
      cyc_d  = CY_NONE;
      mask_d = '1;
    end else if (ras_fall) begin
      mask_d = '1;
      unique case (1'b1)
        ~CAS:                     cyc_d = CY_CBR;
        CAS & ~OE & WE:           cyc_d = CY_RX;
        CAS & ~OE & ~WE:          cyc_d = CY_WX;
        CAS & OE & ~WE & WPB_EN: begin
          cyc_d  = CY_WPB;
          mask_d = RD_i;
        end
        default:                  cyc_d = CY_NORM;
      endcase
    end
  end

  always_ff @(posedge MCLK) begin
    if (reset) begin
      ras_q   <= 1'b1;
      cas_q   <= 1'b0;
      oe_q    <= 1'b1;
      sc_q    <= 1'b1;
      row_q   <= '0;
      col_q   <= '0;
      ptr_q   <= '0;
      mode_in <= 1'b0;
      cyc_q   <= CY_NONE;
      mask_q  <= '1;
      RD_o    <= '0;
      SD_o    <= '0;
    end else begin
      ras_q  <= RAS;
      cas_q  <= cas_act;
      oe_q   <= OE;
      sc_q   <= SC;
      cyc_q  <= cyc_d;
      mask_q <= mask_d;
      RD_o   <= mem[{row_q, col_q}];
      if (ras_fall && CAS)
        row_q <= AD[ROW_W-1:0];
      if (col_lat)
        col_q <= AD[COL_W-1:0];
      // a transfer owns the pointer; a coincident SC edge is lost
      if (rx) begin
        ptr_q   <= col_q;
        mode_in <= 1'b0;
      end else if (wx) begin
        ptr_q   <= col_eff;
        mode_in <= 1'b1;
      end else if (sc_rise) begin
        if (!mode_in) begin
          SD_o  <= sam[ptr_q];
          ptr_q <= ptr_q + COL_W'(1);
        end else if (!SE) begin
          ptr_q <= ptr_q + COL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge MCLK) begin
    if (do_wr)
      mem[waddr] <= (RD_i & mask_q) | (mem[waddr] & ~mask_q);
    if (wx && !reset)
      for (int i = 0; i < SAM_N; i++)
        mem[{row_q, COL_W'(i)}] <= sam[i];
  end

  always_ff @(posedge MCLK) begin
    if (rx && !reset) begin
      for (int i = 0; i < SAM_N; i++)
        sam[i] <= mem[{row_q, COL_W'(i)}];
    end else if (sc_rise && mode_in && !SE && !wx && !reset) begin
      sam[ptr_q] <= SD_i;
    end
  end

endmodule

// File: tb/tb_vram_gen.sv
// tb_vram_gen: scoreboard bench for vram_gen, two instances with
// write-per-bit enabled (u_a) and disabled (u_b) on shared strobes.
module tb_vram_gen;

  logic       MCLK = 1'b0;
  logic       reset;
  logic       RAS, CAS, WE, OE, SC, SE;
  logic [7:0] AD, RD_i, SD_i;
  logic [7:0] rdo_a, rdo_b, sdo_a, sdo_b;
  logic       rdd_a, rdd_b, sdd_a, sdd_b;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];
  string      tag_q [$];

  always #5 MCLK = ~MCLK;

  vram_gen #(.WPB_EN(1'b1)) u_a (
    .MCLK(MCLK), .reset(reset),
    .RAS(RAS), .CAS(CAS), .WE(WE), .OE(OE),
    .SC(SC), .SE(SE), .AD(AD),
    .RD_i(RD_i), .RD_o(rdo_a), .RD_d(rdd_a),
    .SD_i(SD_i), .SD_o(sdo_a), .SD_d(sdd_a)
  );

  vram_gen #(.WPB_EN(1'b0)) u_b (
    .MCLK(MCLK), .reset(reset),
    .RAS(RAS), .CAS(CAS), .WE(WE), .OE(OE),
    .SC(SC), .SE(SE), .AD(AD),
    .RD_i(RD_i), .RD_o(rdo_b), .RD_d(rdd_b),
    .SD_i(SD_i), .SD_o(sdo_b), .SD_d(sdd_b)
  );

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [7:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic sb_pop(input logic [7:0] got);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty: got %0h, expected none", got);
    end else begin
      check(tag_q.pop_front(), got, exp_q.pop_front());
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge MCLK);
    #1;
  endtask

  task automatic ras_down(input logic [7:0] r, input logic oe,
                          input logic we, input logic [7:0] d);
    AD = r; OE = oe; WE = we; RD_i = d; RAS = 1'b0;
    tick(2);
  endtask

  task automatic cas_down(input logic [7:0] c, input logic we,
                          input logic [7:0] d);
    AD = c; WE = we; RD_i = d; CAS = 1'b0;
    tick(2);
  endtask

  task automatic cas_up();
    CAS = 1'b1; WE = 1'b1;
    tick(2);
  endtask

  task automatic ras_up();
    RAS = 1'b1; CAS = 1'b1; OE = 1'b1; WE = 1'b1;
    tick(2);
  endtask

  task automatic wr(input logic [7:0] r, input logic [7:0] c,
                    input logic [7:0] d);
    ras_down(r, 1'b1, 1'b1, 8'h00);
    cas_down(c, 1'b0, d);
    cas_up();
    ras_up();
  endtask

  task automatic rd(input logic [7:0] r, input logic [7:0] c,
                    output logic [7:0] a, output logic [7:0] b,
                    output logic dd);
    ras_down(r, 1'b1, 1'b1, 8'h00);
    cas_down(c, 1'b1, 8'h00);
    OE = 1'b0;
    tick(3);
    a = rdo_a; b = rdo_b; dd = rdd_a;
    OE = 1'b1;
    tick(1);
    cas_up();
    ras_up();
  endtask

  task automatic sc_pulse();
    SC = 1'b1;
    tick(2);
    SC = 1'b0;
    tick(2);
  endtask

  initial begin
    logic [7:0] a, b;
    logic       dd;

    reset = 1'b1;
    RAS = 1'b1; CAS = 1'b1; WE = 1'b1; OE = 1'b1;
    SC = 1'b0; SE = 1'b1;
    AD = 8'h00; RD_i = 8'h00; SD_i = 8'h00;
    tick(3);
    check("rst_rdo", rdo_a, 8'h00);
    check("rst_rdd", 8'(rdd_a), 8'h01);
    check("rst_sdo", sdo_a, 8'h00);
    check("rst_sdd", 8'(sdd_a), 8'h01);
    reset = 1'b0;
    tick(2);
    check("idle_rdd", 8'(rdd_a), 8'h01);

    // normal write then read
    wr(8'h12, 8'h34, 8'hA5);
    sb_push("norm_rd", 8'hA5);
    rd(8'h12, 8'h34, a, b, dd);
    sb_pop(a);
    check("norm_rd_b", b, 8'hA5);
    check("norm_rdd_low", 8'(dd), 8'h00);
    check("norm_rdd_idle", 8'(rdd_a), 8'h01);

    // write-per-bit
    wr(8'h20, 8'h05, 8'hFF);
    ras_down(8'h20, 1'b1, 1'b0, 8'h0F);
    cas_down(8'h05, 1'b0, 8'h00);
    cas_up();
    ras_up();
    sb_push("wpb_on", 8'hF0);
    rd(8'h20, 8'h05, a, b, dd);
    sb_pop(a);
    check("wpb_off", b, 8'h00);

    // fill row 3 with column index using page mode
    ras_down(8'h03, 1'b1, 1'b1, 8'h00);
    for (int c = 0; c < 256; c++) begin
      cas_down(8'(c), 1'b0, 8'(c));
      cas_up();
    end
    ras_up();
    sb_push("page_fill", 8'h9C);
    rd(8'h03, 8'h9C, a, b, dd);
    sb_pop(a);

    // read transfer at col 0xFE, serial out with wrap
    ras_down(8'h03, 1'b0, 1'b1, 8'h00);
    cas_down(8'hFE, 1'b1, 8'h00);
    OE = 1'b1;
    tick(2);
    cas_up();
    ras_up();
    SE = 1'b0;
    tick(1);
    check("rx_sdd", 8'(sdd_a), 8'h00);
    sb_push("rx_sd0", 8'hFE);
    sb_push("rx_sd1", 8'hFF);
    sb_push("rx_sd2", 8'h00);
    for (int k = 0; k < 3; k++) begin
      sc_pulse();
      sb_pop(sdo_a);
    end

    // write transfer of SAM into row 5
    ras_down(8'h05, 1'b0, 1'b0, 8'h00);
    cas_down(8'h00, 1'b1, 8'h00);
    cas_up();
    ras_up();
    check("wx_sdd", 8'(sdd_a), 8'h01);
    sb_push("wx_r5_00", 8'h00);
    rd(8'h05, 8'h00, a, b, dd);
    sb_pop(a);
    sb_push("wx_r5_7f", 8'h7F);
    rd(8'h05, 8'h7F, a, b, dd);
    sb_pop(a);
    sb_push("wx_r5_ff", 8'hFF);
    rd(8'h05, 8'hFF, a, b, dd);
    sb_pop(a);

    // serial input into SAM[0..1]
    SD_i = 8'h11;
    sc_pulse();
    SD_i = 8'h22;
    sc_pulse();
    check("in_sdd", 8'(sdd_a), 8'h01);
    check("in_sdo_hold", sdo_a, 8'h00);
    ras_down(8'h06, 1'b0, 1'b0, 8'h00);
    cas_down(8'h00, 1'b1, 8'h00);
    cas_up();
    ras_up();
    sb_push("in_r6_0", 8'h11);
    rd(8'h06, 8'h00, a, b, dd);
    sb_pop(a);
    sb_push("in_r6_1", 8'h22);
    rd(8'h06, 8'h01, a, b, dd);
    sb_pop(a);
    sb_push("in_r6_2", 8'h02);
    rd(8'h06, 8'h02, a, b, dd);
    sb_pop(a);

    // SC rise coincident with read-transfer OE rise
    ras_down(8'h03, 1'b0, 1'b1, 8'h00);
    cas_down(8'h10, 1'b1, 8'h00);
    OE = 1'b1;
    SC = 1'b1;
    tick(2);
    sb_push("col_sdo_hold", 8'h00);
    sb_pop(sdo_a);
    SC = 1'b0;
    tick(2);
    cas_up();
    ras_up();
    sb_push("col_ptr", 8'h10);
    sc_pulse();
    sb_pop(sdo_a);

    // CAS-before-RAS refresh
    CAS = 1'b0;
    tick(2);
    AD = 8'h99;
    RAS = 1'b0;
    tick(2);
    AD = 8'h77;
    tick(2);
    RAS = 1'b1;
    tick(2);
    CAS = 1'b1;
    tick(2);
    check("cbr_rowcol", rdo_a, 8'h10);
    sb_push("cbr_mem", 8'hA5);
    rd(8'h12, 8'h34, a, b, dd);
    sb_pop(a);

    // reset in the middle of a write
    SE = 1'b1;
    ras_down(8'h40, 1'b1, 1'b1, 8'h00);
    cas_down(8'h01, 1'b0, 8'h3C);
    RD_i = 8'hC3;
    reset = 1'b1;
    tick(2);
    check("mid_rst_rdo", rdo_a, 8'h00);
    check("mid_rst_rdd", 8'(rdd_a), 8'h01);
    check("mid_rst_sdo", sdo_a, 8'h00);
    check("mid_rst_sdd", 8'(sdd_a), 8'h01);
    reset = 1'b0;
    tick(4);
    check("post_rst_rdd", 8'(rdd_a), 8'h01);
    ras_up();
    sb_push("rst_nowr", 8'h3C);
    rd(8'h40, 8'h01, a, b, dd);
    sb_pop(a);
    wr(8'h40, 8'h01, 8'h77);
    sb_push("rst_recover", 8'h77);
    rd(8'h40, 8'h01, a, b, dd);
    sb_pop(a);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_left: got %0d, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
